// File: rtl/hazard_scoreboard.sv
// Load-use hazard detection and operand forwarding for an in-order pipeline.
// Optional perf counters compile in only when HAZARD_PERF_EN is defined.

module hazard_entry #(
  parameter int REG_W    = 5,
  parameter int ZERO_REG = 31
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             in_wr,
  input  logic             in_load,
  input  logic [REG_W-1:0] in_rd,
  input  logic [REG_W-1:0] rn,
  input  logic [REG_W-1:0] rm,
  output logic             valid,
  output logic             wr,
  output logic             is_load,
  output logic [REG_W-1:0] rd,
  output logic             hit_a,
  output logic             hit_b
);
  localparam logic [REG_W-1:0] ZR = REG_W'(ZERO_REG);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid   <= 1'b0;
      wr      <= 1'b0;
      is_load <= 1'b0;
      rd      <= '0;
    end else begin
      valid   <= in_valid;
      wr      <= in_wr;
      is_load <= in_load;
      rd      <= in_rd;
    end
  end

  // The zero register is qualified on the source side so XZR never hits.
  assign hit_a = valid & wr & (rd == rn) & (rn != ZR);
  assign hit_b = valid & wr & (rd == rm) & (rm != ZR);
endmodule

module hazard_scoreboard #(
  parameter int REG_W      = 5,
  parameter int DEPTH      = 3,
  parameter int LOAD_STAGE = 1,
  parameter int ZERO_REG   = 31,
  parameter int FW         = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic             id_rn_used,
  input  logic             id_rm_used,
  input  logic             id_wr,
  input  logic             id_is_load,
  input  logic [REG_W-1:0] id_rn,
  input  logic [REG_W-1:0] id_rm,
  input  logic [REG_W-1:0] id_rd,
  input  logic             flush,
  output logic             pc_en,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             bubble,
  output logic [FW-1:0]    fwd_a,
  output logic [FW-1:0]    fwd_b,
  output logic [31:0]      stall_cnt,
  output logic [31:0]      flush_cnt
);
  logic [DEPTH-1:0]            vld_pipe, ent_wr, ent_load, hit_a, hit_b;
  logic [DEPTH-1:0][REG_W-1:0] ent_rd;
  logic [DEPTH-1:0]            src_valid, src_wr, src_load;
  logic [DEPTH-1:0][REG_W-1:0] src_rd;
  logic                        stall, stall_a, stall_b, accept;
  logic [FW-1:0]               sel_a, sel_b;

  // Entry 0 takes the ID instruction or a bubble; older entries shift down.
  always_comb begin
    src_valid    = '0;
    src_wr       = '0;
    src_load     = '0;
    src_rd       = '0;
    src_valid[0] = accept;
    src_wr[0]    = accept & id_wr;
    src_load[0]  = accept & id_is_load;
    src_rd[0]    = id_rd;
    for (int k = 1; k < DEPTH; k++) begin
      src_valid[k] = vld_pipe[k-1];
      src_wr[k]    = ent_wr[k-1];
      src_load[k]  = ent_load[k-1];
      src_rd[k]    = ent_rd[k-1];
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_ent
    hazard_entry #(.REG_W(REG_W), .ZERO_REG(ZERO_REG)) u_ent (
      .clk     (clk),
      .reset   (reset),
      .in_valid(src_valid[k]),
      .in_wr   (src_wr[k]),
      .in_load (src_load[k]),
      .in_rd   (src_rd[k]),
      .rn      (id_rn),
      .rm      (id_rm),
      .valid   (vld_pipe[k]),
      .wr      (ent_wr[k]),
      .is_load (ent_load[k]),
      .rd      (ent_rd[k]),
      .hit_a   (hit_a[k]),
      .hit_b   (hit_b[k])
    );
  end

  // Scan oldest to youngest so the youngest match wins, stall decision included.
  always_comb begin
    sel_a   = '0;
    sel_b   = '0;
    stall_a = 1'b0;
    stall_b = 1'b0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (id_rn_used && hit_a[k]) begin
        sel_a   = FW'(k + 1);
        stall_a = ent_load[k] && (k < LOAD_STAGE);
      end
      if (id_rm_used && hit_b[k]) begin
        sel_b   = FW'(k + 1);
        stall_b = ent_load[k] && (k < LOAD_STAGE);
      end
    end
  end

  assign stall      = id_valid & (stall_a | stall_b);
  assign accept     = id_valid & ~stall & ~flush;
  assign fwd_a      = sel_a;
  assign fwd_b      = sel_b;
  assign pc_en      = flush | ~stall;
  assign ifid_write = flush | ~stall;
  assign ifid_flush = flush;
  assign bubble     = flush | stall;

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && !flush && stall_cnt != 32'hFFFF_FFFF) stall_cnt <= stall_cnt + 32'd1;
      if (flush && flush_cnt != 32'hFFFF_FFFF)           flush_cnt <= flush_cnt + 32'd1;
    end
  end
`else
  assign stall_cnt = 32'd0;
  assign flush_cnt = 32'd0;
`endif
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench for hazard_scoreboard: directed hazard cases plus random
// traffic, checked against an in-flight instruction queue model.

module tb_hazard_scoreboard;
  localparam int REG_W = 5, DEPTH = 3, LOAD_STAGE = 1, ZERO_REG = 31;
  localparam int FW = $clog2(DEPTH + 1);

  logic clk = 1'b0, reset = 1'b0;
  logic id_valid = 0, id_rn_used = 0, id_rm_used = 0, id_wr = 0, id_is_load = 0, flush = 0;
  logic [REG_W-1:0] id_rn = '0, id_rm = '0, id_rd = '0;
  logic pc_en, ifid_write, ifid_flush, bubble;
  logic [FW-1:0] fwd_a, fwd_b;
  logic [31:0] stall_cnt, flush_cnt;

  hazard_scoreboard #(.REG_W(REG_W), .DEPTH(DEPTH), .LOAD_STAGE(LOAD_STAGE), .ZERO_REG(ZERO_REG)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rn_used(id_rn_used), .id_rm_used(id_rm_used),
    .id_wr(id_wr), .id_is_load(id_is_load), .id_rn(id_rn), .id_rm(id_rm), .id_rd(id_rd), .flush(flush),
    .pc_en(pc_en), .ifid_write(ifid_write), .ifid_flush(ifid_flush), .bubble(bubble),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt));

  always #5 clk = ~clk;

  typedef struct { logic v, wr, ld; logic [REG_W-1:0] rd; } ent_t;
  typedef struct { logic v, ua, ub, wr, ld, fl; logic [REG_W-1:0] rn, rm, rd; } in_t;
  typedef struct { logic pc_en, ifid_write, ifid_flush, bubble; int fa, fb; logic [31:0] sc, fc; } exp_t;

  ent_t pipe[$];     // index 0 = youngest in-flight instruction
  exp_t expq[$];
  int nvec = 0, nbad = 0;
  logic [31:0] m_sc = 0, m_fc = 0;
  logic last_stall = 0;

  function automatic in_t mk(logic v, logic ua, logic ub, logic wr, logic ld,
                             int rn, int rm, int rd, logic fl);
    in_t i;
    i.v = v; i.ua = ua; i.ub = ub; i.wr = wr; i.ld = ld; i.fl = fl;
    i.rn = REG_W'(rn); i.rm = REG_W'(rm); i.rd = REG_W'(rd);
    return i;
  endfunction

  // Position of the youngest in-flight writer of r, or -1.
  function automatic int youngest(logic [REG_W-1:0] r);
    if (r == REG_W'(ZERO_REG)) return -1;
    for (int k = 0; k < DEPTH; k++)
      if (pipe[k].v && pipe[k].wr && pipe[k].rd == r) return k;
    return -1;
  endfunction

  task automatic clear_model();
    pipe.delete();
    for (int k = 0; k < DEPTH; k++) pipe.push_back('{v:0, wr:0, ld:0, rd:'0});
    m_sc = 0; m_fc = 0;
  endtask

  task automatic cycle(input in_t i, input logic rst_v);
    int ka, kb;
    logic st;
    exp_t e;
    ent_t n;
    @(posedge clk); #1;
    reset = rst_v; id_valid = i.v; id_rn_used = i.ua; id_rm_used = i.ub; id_wr = i.wr;
    id_is_load = i.ld; id_rn = i.rn; id_rm = i.rm; id_rd = i.rd; flush = i.fl;
    if (!rst_v) clear_model();
    ka = i.ua ? youngest(i.rn) : -1;
    kb = i.ub ? youngest(i.rm) : -1;
    st = i.v && ((ka >= 0 && pipe[ka].ld && ka < LOAD_STAGE) ||
                 (kb >= 0 && pipe[kb].ld && kb < LOAD_STAGE));
    e.fa = ka + 1; e.fb = kb + 1;
    e.ifid_flush = i.fl;
    e.pc_en = i.fl || !st; e.ifid_write = i.fl || !st; e.bubble = i.fl || st;
    e.sc = m_sc; e.fc = m_fc;
    expq.push_back(e);
    last_stall = st && !i.fl;
    if (rst_v) begin
      n.v = i.v && !st && !i.fl; n.wr = n.v && i.wr; n.ld = n.v && i.ld; n.rd = i.rd;
      pipe.push_front(n);
      void'(pipe.pop_back());
`ifdef HAZARD_PERF_EN
      if (st && !i.fl && m_sc != 32'hFFFF_FFFF) m_sc++;
      if (i.fl && m_fc != 32'hFFFF_FFFF) m_fc++;
`endif
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (expq.size() > 0) begin
      exp_t e;
      e = expq.pop_front();
      chk("pc_en", 32'(pc_en), 32'(e.pc_en));
      chk("ifid_write", 32'(ifid_write), 32'(e.ifid_write));
      chk("ifid_flush", 32'(ifid_flush), 32'(e.ifid_flush));
      chk("bubble", 32'(bubble), 32'(e.bubble));
      chk("fwd_a", 32'(fwd_a), 32'(e.fa));
      chk("fwd_b", 32'(fwd_b), 32'(e.fb));
      chk("stall_cnt", stall_cnt, e.sc);
      chk("flush_cnt", flush_cnt, e.fc);
    end
  end

  function automatic int pick_reg();
    case ($urandom_range(0, 4))
      0: return 1;
      1: return 2;
      2: return 3;
      3: return 31;
      default: return $urandom_range(0, 31);
    endcase
  endfunction

  in_t idle, cur;

  initial begin
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    clear_model();
    cycle(idle, 0);
    cycle(idle, 0);
    cycle(idle, 1);
    cycle(idle, 1);
    // ADD X1 then consumer on rn
    cycle(mk(1, 1, 1, 1, 0, 5, 6, 1, 0), 1);
    cycle(mk(1, 1, 0, 0, 0, 1, 0, 0, 0), 1);
    // LDUR X2 then consumer on rm: one stall, then forward from entry 1
    cycle(mk(1, 1, 0, 1, 1, 7, 0, 2, 0), 1);
    cycle(mk(1, 0, 1, 1, 0, 0, 2, 8, 0), 1);
    cycle(mk(1, 0, 1, 1, 0, 0, 2, 8, 0), 1);
    // ADD X3, SUB X3, consumer: youngest wins
    cycle(mk(1, 0, 0, 1, 0, 0, 0, 3, 0), 1);
    cycle(mk(1, 0, 0, 1, 0, 0, 0, 3, 0), 1);
    cycle(mk(1, 1, 1, 0, 0, 3, 3, 0, 0), 1);
    // XZR never hazards, even as a load destination
    cycle(mk(1, 0, 0, 1, 1, 0, 0, 31, 0), 1);
    cycle(mk(1, 1, 1, 1, 0, 31, 31, 31, 0), 1);
    // load-use with simultaneous flush
    cycle(mk(1, 0, 0, 1, 1, 0, 0, 4, 0), 1);
    cycle(mk(1, 1, 0, 1, 0, 4, 0, 9, 1), 1);
    cycle(mk(1, 1, 1, 0, 0, 4, 9, 0, 0), 1);
    // reset pulsed during a stall
    cycle(mk(1, 0, 0, 1, 1, 0, 0, 5, 0), 1);
    cycle(mk(1, 0, 1, 1, 0, 0, 5, 10, 0), 1);
    cycle(mk(1, 0, 1, 1, 0, 0, 5, 10, 0), 0);
    cycle(idle, 0);
    cycle(mk(1, 0, 1, 1, 0, 0, 5, 10, 0), 1);
    cycle(idle, 1);
    // random traffic; a stalled ID instruction is held until it issues
    cur = idle;
    for (int n = 0; n < 600; n++) begin
      logic rst_v;
      if (!last_stall) begin
        cur.v  = ($urandom_range(0, 9) != 0);
        cur.ua = cur.v && $urandom_range(0, 1);
        cur.ub = cur.v && $urandom_range(0, 1);
        cur.wr = $urandom_range(0, 3) != 0;
        cur.ld = $urandom_range(0, 1);
        cur.rn = REG_W'(pick_reg());
        cur.rm = REG_W'(pick_reg());
        cur.rd = REG_W'(pick_reg());
      end
      cur.fl = ($urandom_range(0, 9) == 0);
      rst_v = ($urandom_range(0, 99) != 0);
      cycle(cur, rst_v);
    end
    cycle(idle, 1);
    @(negedge clk);
    @(negedge clk);
    chk("queue_drained", 32'(expq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end
endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter REG_W, default 5, register-index width.
REQ-002 SHALL have parameter DEPTH, default 3, number of in-flight stages tracked after ID (entry 0 = youngest/EX).
REQ-003 SHALL have parameter LOAD_STAGE, default 1, lowest entry index from which a load result is forwardable (1 <= LOAD_STAGE <= DEPTH).
REQ-004 SHALL have parameter ZERO_REG, default 31, register index that never creates a hazard (XZR).
REQ-005 SHALL have port clk  in  1  the single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-007 SHALL have ports id_valid, id_rn_used, id_rm_used, id_wr, id_is_load  in  1 each  ID-stage instruction qualifiers.
REQ-008 SHALL have ports id_rn, id_rm, id_rd  in  REG_W each  ID-stage source/destination indices.
REQ-009 SHALL have port flush  in  1  taken branch resolved; squash the ID instruction.
REQ-010 SHALL have ports pc_en, ifid_write, ifid_flush, bubble  out  1 each  fetch enable, IF/ID hold, IF/ID clear, control-mux zero select.
REQ-011 SHALL have ports fwd_a, fwd_b  out  FW=$clog2(DEPTH+1) each  operand source: 0 = regfile, k+1 = entry k.
REQ-012 SHALL have ports stall_cnt, flush_cnt  out  32 each  performance counters (see Configuration).

Function
REQ-013 SHALL hold DEPTH entries {valid, rd, wr, is_load}; every cycle entry k moves to k+1 and entry DEPTH-1 retires.
REQ-014 SHALL load entry 0 with the ID instruction when id_valid=1, stall=0, flush=0; otherwise with an invalid bubble.
REQ-015 SHALL define match(k,r) = entry k valid & wr & rd==r & r!=ZERO_REG.
REQ-016 SHALL raise internal stall when id_valid and, for a used source r, match(k,r) with is_load and k<LOAD_STAGE, taking the youngest matching entry only.
REQ-017 SHALL drive fwd_a/fwd_b combinationally as k+1 for the youngest k with match(k,rn/rm) and source used, else 0; an unused source gives 0.
REQ-018 SHALL NOT let an older matching entry override a younger one (youngest wins), including when the youngest is a stalling load.
REQ-019 SHALL drive with stall & ~flush: pc_en=0, ifid_write=0, bubble=1, ifid_flush=0.
REQ-020 SHALL drive with flush: pc_en=1, ifid_write=1, ifid_flush=1, bubble=1; flush overrides a simultaneous stall.
REQ-021 SHALL drive otherwise: pc_en=1, ifid_write=1, ifid_flush=0, bubble=0.
REQ-022 SHALL make all outputs combinational from inputs and entry state, with no added latency; state changes are visible on the cycle after the edge.
REQ-023 SHALL resolve a stall within LOAD_STAGE cycles, because the stalling load ages one entry per cycle.

Reset
REQ-024 SHALL clear all entry valid bits and both counters asynchronously while reset=0.
REQ-025 SHALL, out of reset with idle inputs, drive pc_en=1, ifid_write=1, ifid_flush=0, bubble=0, fwd_a=fwd_b=0.
REQ-026 SHALL, when reset is asserted mid-stall, discard the in-flight load, so stall=0 the next cycle after release.

Configuration
REQ-027 SHALL compile stall_cnt/flush_cnt logic only when macro HAZARD_PERF_EN is defined.
REQ-028 SHALL, with HAZARD_PERF_EN, increment stall_cnt on each cycle with stall & ~flush and flush_cnt on each cycle with flush, saturating both at 32'hFFFFFFFF.
REQ-029 SHALL, without HAZARD_PERF_EN, keep the counter ports and tie both to 0.

Verification (DEPTH=3, LOAD_STAGE=1)
REQ-030 SHALL check: ADD X1 issued, next ID reads rn=1 -> fwd_a=1, stall=0.
REQ-031 SHALL check: LDUR X2 issued, next ID reads rm=2 -> one cycle stall (pc_en=0, bubble=1), then fwd_b=2, stall=0.
REQ-032 SHALL check: ADD X3 then SUB X3, then ID reads rn=3 -> fwd_a=1 (youngest), not 2.
REQ-033 SHALL check: ID writes and reads X31 -> fwd_a=fwd_b=0, no stall.
REQ-034 SHALL check: load-use stall with flush=1 the same cycle -> pc_en=1, ifid_flush=1, entry 0 bubble, and flush_cnt+1 only when HAZARD_PERF_EN is defined.
REQ-035 SHALL check: reset=0 pulsed during a stall -> all outputs at reset values, counters 0, and no stall after release.
